wave_loader: RTL and testbench
==============================

# wave_loader

Loads a 256x8 wavetable into the DDS sine RAM through its write port (`data`, `wraddress`, `wren`) from an incoming byte stream, such as a UART receiver. It sits between the byte source and the RAM, alongside the DDS phase counter that reads the RAM. The block frames each table with a header byte, writes data bytes at sequential addresses, optionally checks a checksum, and times out on stalled transfers.

## Interface
- `AW`, 8, RAM address width; table depth is 2**AW.
- `DW`, 8, data width.
- `HEADER`, 8'hA5, start-of-table byte.
- `TIMEOUT`, 1_000_000, maximum idle gap in clock cycles between bytes while loading.
- `s_clk`  in  1  system clock.
- `s_rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  DW  incoming byte.
- `rx_vld`  in  1  one-cycle strobe; `rx_data` is valid while it is high.
- `wr_data`  out  DW  RAM write data.
- `wr_addr`  out  AW  RAM write address.
- `wr_en`  out  1  RAM write enable.
- `load_busy`  out  1  high while a table load is in progress.
- `load_done`  out  1  one-cycle pulse on a successful load.
- `load_err`  out  1  one-cycle pulse on a checksum mismatch or timeout.

## Operation
- States are IDLE, LOAD and CHK. CHK exists only with the checksum feature enabled.
- IDLE:
  - On `rx_vld` with `rx_data==HEADER`, go to LOAD.
  - On entry to LOAD, clear the byte index, the checksum accumulator and the timeout counter.
  - Any other byte is ignored.
- LOAD:
  - Each `rx_vld` byte is written to RAM at the current index.
  - The byte is added mod 2**DW to the accumulator, and the index increments.
  - A HEADER value inside LOAD is treated as ordinary data.
  - After byte index 2**AW-1:
    - With the checksum feature, go to CHK.
    - Without it, pulse `load_done` and go to IDLE.
- CHK:
  - On the next `rx_vld`, compare the received byte with the accumulator.
  - On a match, pulse `load_done`; on a mismatch, pulse `load_err`.
  - Go to IDLE in either case.
- Timeout:
  - In LOAD or CHK, the counter increments every cycle without `rx_vld` and clears on `rx_vld`.
  - When the counter reaches TIMEOUT-1, pulse `load_err` and go to IDLE.
  - `rx_vld` in that same cycle is accepted and timeout does not fire.
- RAM contents are never rolled back. A failed or aborted load leaves a partially written table, and `load_err` tells the host to reload.
- `load_busy` = state is not IDLE, driven from a register.

## Timing
- All outputs are registered. Reset values: `wr_data`=0, `wr_addr`=0, `wr_en`=0, `load_busy`=0, `load_done`=0, `load_err`=0.
- Write latency: an `rx_vld` data byte in cycle N produces `wr_en`=1 with the byte and its address in cycle N+1. `wr_en` lasts exactly one cycle.
- The index wraps from 2**AW-1 to 0 only via the state exit. Exactly 2**AW writes occur per load.
- `load_done` and `load_err` assert in the cycle after the deciding byte or timeout. `load_busy` falls in that same cycle.
- With the checksum feature off, `load_done` asserts in the same cycle as the final `wr_en`.
- Back-to-back `rx_vld` every cycle is supported with no drops.
- Asynchronous reset mid-load immediately forces IDLE and zeros all outputs. No further writes occur.

## Configuration
- `WAVE_LOADER_CHKSUM_EN` defined:
  - The CHK state and the accumulator are compiled in.
  - A frame is HEADER, then 2**AW data bytes, then 1 checksum byte.
- Undefined:
  - There is no CHK state and no accumulator.
  - A frame is HEADER plus 2**AW data bytes.
  - `load_err` can come only from a timeout.

## Test plan
- Reset, then send 0x11 and 0x22 without a header → no `wr_en`, `load_busy`=0.
- Send 0xA5, then bytes 0x00..0xFF, then checksum 0x80 (sum of 0..255 mod 256), with the macro defined → 256 writes with `wr_addr`==`wr_data`, `load_done` pulses once, `load_err`=0.
- Same frame with checksum 0x81 → 256 writes, `load_err` pulses once, `load_done`=0.
- Macro undefined, send 0xA5 and 256 bytes of 0x5A back-to-back → `load_done` in the cycle of the write at address 0xFF, with no gaps in `wr_en`.
- TIMEOUT=16, send 0xA5 and 10 bytes, then idle → `load_err` pulses 16 cycles after the last byte. A following 0xA5 restarts writing at address 0.
- Assert `s_rst_n` low after 100 data bytes → all outputs 0 immediately. After release, bytes without a header produce no writes.

Source files
------------

// File: rtl/wave_loader.sv
// wave_loader: frames a byte stream (HEADER + 2**AW data bytes) into
// sequential RAM writes, with an idle-gap timeout while loading.
// Optional feature macro: WAVE_LOADER_CHKSUM_EN adds a trailing checksum
// byte (sum of data bytes mod 2**DW) checked in a CHK state.
module wave_loader #(
  parameter int             AW      = 8,
  parameter int             DW      = 8,
  parameter logic [DW-1:0]  HEADER  = 8'hA5,
  parameter int             TIMEOUT = 1_000_000
) (
  input  logic          s_clk,
  input  logic          s_rst_n,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_vld,
  output logic [DW-1:0] wr_data,
  output logic [AW-1:0] wr_addr,
  output logic          wr_en,
  output logic          load_busy,
  output logic          load_done,
  output logic          load_err
);

`ifdef WAVE_LOADER_CHKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHK} state_t;
`else
  typedef enum logic {IDLE, LOAD} state_t;
`endif

  localparam int            TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Counter reaching TIMEOUT-1 fires: compare against the pre-increment value.
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 2);
  localparam logic [AW-1:0] ILAST = '1;

  state_t        state, state_d;
  logic [AW-1:0] idx, idx_d;
  logic [TW-1:0] cnt, cnt_d;
  logic [DW-1:0] wr_data_d;
  logic [AW-1:0] wr_addr_d;
  logic          wr_en_d, busy_d, done_d, err_d;
`ifdef WAVE_LOADER_CHKSUM_EN
  logic [DW-1:0] acc, acc_d;
`endif

  // State register
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state, datapath and registered-output next values
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cnt_d     = cnt;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data;
    wr_addr_d = wr_addr;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef WAVE_LOADER_CHKSUM_EN
    acc_d     = acc;
`endif
    case (state)
      IDLE: begin
        if (rx_vld && (rx_data == HEADER)) begin
          state_d = LOAD;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef WAVE_LOADER_CHKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      LOAD: begin
        if (rx_vld) begin
          cnt_d     = '0;
          wr_en_d   = 1'b1;
          wr_data_d = rx_data;
          wr_addr_d = idx;
          idx_d     = idx + 1'b1;
`ifdef WAVE_LOADER_CHKSUM_EN
          acc_d     = acc + rx_data;
          if (idx == ILAST) state_d = CHK;
`else
          if (idx == ILAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`endif
        end else if (cnt == TLAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`ifdef WAVE_LOADER_CHKSUM_EN
      CHK: begin
        if (rx_vld) begin
          state_d = IDLE;
          if (rx_data == acc) done_d = 1'b1;
          else                err_d  = 1'b1;
        end else if (cnt == TLAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      idx       <= '0;
      cnt       <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      wr_addr   <= '0;
      load_busy <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
`ifdef WAVE_LOADER_CHKSUM_EN
      acc       <= '0;
`endif
    end else begin
      idx       <= idx_d;
      cnt       <= cnt_d;
      wr_en     <= wr_en_d;
      wr_data   <= wr_data_d;
      wr_addr   <= wr_addr_d;
      load_busy <= busy_d;
      load_done <= done_d;
      load_err  <= err_d;
`ifdef WAVE_LOADER_CHKSUM_EN
      acc       <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_wave_loader.sv
// Bench for wave_loader: vector table, directed multi-cycle sequences and
// randomized frames checked against a frame-level reference model.
module tb_wave_loader;
  localparam int TO    = 16;
  localparam int DEPTH = 256;
`ifdef WAVE_LOADER_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       s_clk = 1'b0;
  logic       s_rst_n;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic [7:0] wr_data;
  logic [7:0] wr_addr;
  logic       wr_en, load_busy, load_done, load_err;

  wave_loader #(.AW(8), .DW(8), .HEADER(8'hA5), .TIMEOUT(TO)) dut (
    .s_clk(s_clk), .s_rst_n(s_rst_n), .rx_data(rx_data), .rx_vld(rx_vld),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 s_clk = ~s_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: frame position, running sum and idle-gap length.
  bit m_active;
  int m_pos, m_sum, m_idle;
  bit e_wr_en, e_busy, e_done, e_err;
  int e_addr, e_data;

  int         n_wr, n_done, n_err;
  logic [7:0] done_addr;
  logic       done_wen;

  typedef struct {
    bit         vld;
    logic [7:0] d;
    bit         w;
    logic [7:0] a;
    logic [7:0] dt;
    bit         busy;
    bit         done;
    bit         err;
  } vec_t;
  vec_t tv[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_pos = 0; m_sum = 0; m_idle = 0;
    e_wr_en = 0; e_busy = 0; e_done = 0; e_err = 0; e_addr = 0; e_data = 0;
  endtask

  task automatic model_step(input bit vld, input logic [7:0] d);
    e_wr_en = 0; e_done = 0; e_err = 0;
    if (!m_active) begin
      if (vld && d == 8'hA5) begin
        m_active = 1; m_pos = 0; m_sum = 0; m_idle = 0;
      end
    end else if (vld) begin
      m_idle = 0;
      if (m_pos < DEPTH) begin
        e_wr_en = 1; e_addr = m_pos; e_data = int'(d);
        m_sum = (m_sum + int'(d)) % 256;
        m_pos++;
        if (m_pos == DEPTH && !CHK_EN) begin
          e_done = 1; m_active = 0;
        end
      end else begin
        if (int'(d) == m_sum) e_done = 1;
        else                  e_err  = 1;
        m_active = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == TO - 1) begin
        e_err = 1; m_active = 0;
      end
    end
    e_busy = m_active;
  endtask

  task automatic observe();
    if (wr_en)     n_wr++;
    if (load_done) begin n_done++; done_addr = wr_addr; done_wen = wr_en; end
    if (load_err)  n_err++;
  endtask

  // One clock: drive, let the DUT sample, advance the model, compare.
  task automatic cycle(input bit vld, input logic [7:0] d);
    rx_vld = vld; rx_data = d;
    @(posedge s_clk);
    model_step(vld, d);
    #1;
    check("wr_en", wr_en, e_wr_en);
    if (e_wr_en) begin
      check("wr_addr", wr_addr, e_addr);
      check("wr_data", wr_data, e_data);
    end
    check("load_busy", load_busy, e_busy);
    check("load_done", load_done, e_done);
    check("load_err", load_err, e_err);
    observe();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'($urandom));
  endtask

  task automatic clr_counts();
    n_wr = 0; n_done = 0; n_err = 0; done_addr = '0; done_wen = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"}, load_busy, 0);
    check({tag, "_done"}, load_done, 0);
    check({tag, "_err"}, load_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int k, g;

    tv[0] = '{1'b1, 8'h11, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b1, 8'h22, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[3] = '{1'b1, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[4] = '{1'b1, 8'h07, 1'b1, 8'h00, 8'h07, 1'b1, 1'b0, 1'b0};
    tv[5] = '{1'b1, 8'hA5, 1'b1, 8'h01, 8'hA5, 1'b1, 1'b0, 1'b0};
    tv[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};

    // Reset values
    s_rst_n = 1'b0; rx_vld = 1'b0; rx_data = 8'h00;
    model_reset();
    clr_counts();
    repeat (2) @(posedge s_clk);
    #1;
    check_zero("reset");
    s_rst_n = 1'b1;

    // Vector table: ignored bytes, header, header-as-data, hold
    for (int i = 0; i < 7; i++) begin
      rx_vld = tv[i].vld; rx_data = tv[i].d;
      @(posedge s_clk);
      model_step(tv[i].vld, tv[i].d);
      #1;
      check("tv_wr_en", wr_en, tv[i].w);
      if (tv[i].w) begin
        check("tv_wr_addr", wr_addr, tv[i].a);
        check("tv_wr_data", wr_data, tv[i].dt);
      end
      check("tv_busy", load_busy, tv[i].busy);
      check("tv_done", load_done, tv[i].done);
      check("tv_err", load_err, tv[i].err);
      observe();
    end
    // Stalled partial load times out
    idle(TO - 2);
    check("tv_timeout_err", n_err, 1);
    check("tv_idle_after", load_busy, 0);

    // Full ramp frame 0x00..0xFF
    clr_counts();
    cycle(1'b1, 8'hA5);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i));
`ifdef WAVE_LOADER_CHKSUM_EN
    cycle(1'b1, 8'h80);
`endif
    idle(3);
    check("ramp_writes", n_wr, DEPTH);
    check("ramp_done", n_done, 1);
    check("ramp_err", n_err, 0);

`ifdef WAVE_LOADER_CHKSUM_EN
    // Bad checksum
    clr_counts();
    cycle(1'b1, 8'hA5);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i));
    cycle(1'b1, 8'h81);
    idle(3);
    check("badsum_writes", n_wr, DEPTH);
    check("badsum_done", n_done, 0);
    check("badsum_err", n_err, 1);
`else
    // Back-to-back constant frame: done coincides with the last write
    clr_counts();
    cycle(1'b1, 8'hA5);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'h5A);
    idle(2);
    check("b2b_writes", n_wr, DEPTH);
    check("b2b_done", n_done, 1);
    check("b2b_done_wen", done_wen, 1);
    check("b2b_done_addr", done_addr, 8'hFF);
`endif

    // Timeout latency: header, 10 bytes, then idle
    clr_counts();
    cycle(1'b1, 8'hA5);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom));
    k = 0;
    do begin
      cycle(1'b0, 8'h00);
      k++;
    end while (!load_err && k < 40);
    check("timeout_cycles_after_byte", k + 1, TO);
    check("timeout_writes", n_wr, 10);

    // A byte on the last permitted cycle is accepted
    clr_counts();
    cycle(1'b1, 8'hA5);
    cycle(1'b1, 8'h01);
    idle(TO - 2);
    cycle(1'b1, 8'h02);
    check("lastcycle_accept_busy", load_busy, 1);
    check("lastcycle_accept_addr", wr_addr, 8'h01);
    idle(TO - 1);
    check("lastcycle_then_timeout", n_err, 1);

    // Restart after timeout begins at address 0
    cycle(1'b1, 8'hA5);
    cycle(1'b1, 8'h3C);
    check("restart_addr", wr_addr, 8'h00);

    // Asynchronous reset mid-load
    for (int i = 1; i < 100; i++) cycle(1'b1, 8'(i));
    s_rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    @(posedge s_clk);
    #1;
    s_rst_n = 1'b1;
    @(posedge s_clk);
    #1;
    clr_counts();
    cycle(1'b1, 8'h11);
    cycle(1'b1, 8'h22);
    cycle(1'b1, 8'h5A);
    idle(3);
    check("postrst_writes", n_wr, 0);
    check("postrst_busy", load_busy, 0);

    // Randomized frames against the model
    for (int f = 0; f < 5; f++) begin
      for (int j = 0; j < 3; j++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h3C;
        cycle(1'b1, b);
        idle($urandom_range(0, 2));
      end
      cycle(1'b1, 8'hA5);
      for (int i = 0; i < DEPTH; i++) begin
        g = ($urandom_range(0, 199) == 0) ? TO + 4 : $urandom_range(0, 3);
        idle(g);
        if (!m_active) break;
        cycle(1'b1, 8'($urandom));
      end
`ifdef WAVE_LOADER_CHKSUM_EN
      if (m_active) begin
        idle($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) cycle(1'b1, 8'(m_sum));
        else                          cycle(1'b1, 8'(m_sum + 1));
      end
`endif
      idle(TO + 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
